simple_bus: RTL and testbench

Single-cycle, address-decoded interconnect that joins NrHosts bus hosts (for example the core data port) to NrDevices memory-mapped devices (RAM, simulator control, timer) in the simple system. Each cycle it picks one requesting host by fixed priority, decodes its address against per-device base/mask pairs, and forwards the request to the matching device. It routes the device response back to the originating host on the following cycle. Unmapped addresses get a bus-generated response.

---
 rtl/simple_bus_if.sv | 46 ++++
 rtl/simple_bus.sv | 150 +++++++++++++++
 tb/tb_simple_bus.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_bus_if.sv
// Signal bundle for simple_bus: host ports, device ports and the address map.
// The "slave" modport is the interconnect's view; "master" is the environment's.
interface simple_bus_if #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                    host_req_i     [NrHosts];
    logic                    host_gnt_o     [NrHosts];
    logic [AddressWidth-1:0] host_addr_i    [NrHosts];
    logic                    host_we_i      [NrHosts];
    logic [DataWidth/8-1:0]  host_be_i      [NrHosts];
    logic [DataWidth-1:0]    host_wdata_i   [NrHosts];
    logic                    host_rvalid_o  [NrHosts];
    logic [DataWidth-1:0]    host_rdata_o   [NrHosts];
    logic                    host_err_o     [NrHosts];

    logic                    device_req_o   [NrDevices];
    logic [AddressWidth-1:0] device_addr_o  [NrDevices];
    logic                    device_we_o    [NrDevices];
    logic [DataWidth/8-1:0]  device_be_o    [NrDevices];
    logic [DataWidth-1:0]    device_wdata_o [NrDevices];
    logic                    device_rvalid_i[NrDevices];
    logic [DataWidth-1:0]    device_rdata_i [NrDevices];
    logic                    device_err_i   [NrDevices];

    logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices];
    logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices];

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        input  device_rvalid_i, device_rdata_i, device_err_i,
        input  cfg_device_addr_base, cfg_device_addr_mask
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        output device_rvalid_i, device_rdata_i, device_err_i,
        output cfg_device_addr_base, cfg_device_addr_mask
    );
endinterface

// File: rtl/simple_bus.sv
// Fixed-priority host arbiter + base/mask address decoder, one transaction per cycle.
// Define SIMPLE_BUS_DECERR_EN to flag unmapped accesses with err=1.
module simple_bus_dec #(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] mask_i,
    output logic          hit_o
);
    assign hit_o = (addr_i & mask_i) == base_i;
endmodule

module simple_bus #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    simple_bus_if.slave  bus
);
`ifdef SIMPLE_BUS_DECERR_EN
    localparam logic DecErr = 1'b1;
`else
    localparam logic DecErr = 1'b0;
`endif

    logic [NrHosts-1:0]      host_oh;
    logic                    host_any;
    logic [AddressWidth-1:0] win_addr;
    logic                    win_we;
    logic [DataWidth/8-1:0]  win_be;
    logic [DataWidth-1:0]    win_wdata;
    logic [NrDevices-1:0]    dev_hit;
    logic [NrDevices-1:0]    dev_oh;
    logic                    dev_any;

    // Response routing state, one-hot so an all-zero host vector means "no transaction".
    logic [NrHosts-1:0]      rsp_host_d, rsp_host_q;
    logic [NrDevices-1:0]    rsp_dev_d, rsp_dev_q;
    logic                    rsp_miss_d, rsp_miss_q;

    logic                    sel_rvalid;
    logic [DataWidth-1:0]    sel_rdata;
    logic                    sel_err;

    always_comb begin
        host_oh  = '0;
        host_any = 1'b0;
        for (int h = 0; h < NrHosts; h++) begin
            if (!host_any && bus.host_req_i[h]) begin
                host_oh[h] = 1'b1;
                host_any   = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_we    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (host_oh[h]) begin
                win_addr  = bus.host_addr_i[h];
                win_we    = bus.host_we_i[h];
                win_be    = bus.host_be_i[h];
                win_wdata = bus.host_wdata_i[h];
            end
        end
    end

    for (genvar d = 0; d < NrDevices; d++) begin : g_dec
        simple_bus_dec #(.AW(AddressWidth)) u_dec (
            .addr_i (win_addr),
            .base_i (bus.cfg_device_addr_base[d]),
            .mask_i (bus.cfg_device_addr_mask[d]),
            .hit_o  (dev_hit[d])
        );
    end

    always_comb begin
        dev_oh  = '0;
        dev_any = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dev_any && dev_hit[d]) begin
                dev_oh[d] = 1'b1;
                dev_any   = 1'b1;
            end
        end
    end

    // Request path; reset masks grants and device strobes combinationally.
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            bus.host_gnt_o[h] = host_oh[h] & ~rst_i;
        end
        for (int d = 0; d < NrDevices; d++) begin
            bus.device_req_o[d]   = dev_oh[d] & host_any & ~rst_i;
            bus.device_addr_o[d]  = win_addr;
            bus.device_we_o[d]    = win_we;
            bus.device_be_o[d]    = win_be;
            bus.device_wdata_o[d] = win_wdata;
        end
    end

    always_comb begin
        rsp_host_d = host_oh;
        rsp_dev_d  = dev_oh;
        rsp_miss_d = host_any & ~dev_any;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_host_q <= '0;
            rsp_dev_q  <= '0;
            rsp_miss_q <= 1'b0;
        end else begin
            rsp_host_q <= rsp_host_d;
            rsp_dev_q  <= rsp_dev_d;
            rsp_miss_q <= rsp_miss_d;
        end
    end

    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        sel_err    = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (rsp_dev_q[d]) begin
                sel_rvalid = bus.device_rvalid_i[d];
                sel_rdata  = bus.device_rdata_i[d];
                sel_err    = bus.device_err_i[d];
            end
        end
        // Unmapped access: the bus answers on behalf of the missing device.
        if (rsp_miss_q) begin
            sel_rvalid = 1'b1;
            sel_rdata  = '0;
            sel_err    = DecErr;
        end
        for (int h = 0; h < NrHosts; h++) begin
            bus.host_rvalid_o[h] = rsp_host_q[h] & sel_rvalid;
            bus.host_rdata_o[h]  = rsp_host_q[h] ? sel_rdata : '0;
            bus.host_err_o[h]    = rsp_host_q[h] & sel_err;
        end
    end
endmodule

// File: tb/tb_simple_bus.sv
// Bench for simple_bus: directed vector table, hand-written arbitration/reset
// sequences, and random traffic against a transaction-level reference model.
module tb_simple_bus;
    localparam int NH = 2;
    localparam int ND = 3;
`ifdef SIMPLE_BUS_DECERR_EN
    localparam logic DECERR = 1'b1;
`else
    localparam logic DECERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    simple_bus_if #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) bus ();

    simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NH-1:0] req;
        logic [31:0]   addr0;
        logic [31:0]   addr1;
        logic          we;
        logic [3:0]    be;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          err;
        logic [NH-1:0] exp_gnt;
        logic [ND-1:0] exp_dreq;
        logic          exp_rvalid;
        logic [31:0]   exp_rdata;
        logic          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NH-1:0] gnt_v();
        logic [NH-1:0] g;
        for (int h = 0; h < NH; h++) g[h] = bus.host_gnt_o[h];
        return g;
    endfunction

    function automatic logic [ND-1:0] dreq_v();
        logic [ND-1:0] r;
        for (int d = 0; d < ND; d++) r[d] = bus.device_req_o[d];
        return r;
    endfunction

    // Reference decode: first window in index order that contains the address.
    function automatic int decode(input logic [31:0] a);
        for (int d = 0; d < ND; d++)
            if ((a & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d]) return d;
        return -1;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
            1:       return 32'h0002_0000 | ($urandom & 32'h0000_03FF);
            2:       return 32'h0003_0000 | ($urandom & 32'h0000_03FF);
            3:       return 32'h0002_0000 | ($urandom & 32'h0001_FFFF);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_idle();
        for (int h = 0; h < NH; h++) begin
            bus.host_req_i[h]   = 1'b0;
            bus.host_addr_i[h]  = '0;
            bus.host_we_i[h]    = 1'b0;
            bus.host_be_i[h]    = '0;
            bus.host_wdata_i[h] = '0;
        end
        for (int d = 0; d < ND; d++) begin
            bus.device_rvalid_i[d] = 1'b0;
            bus.device_rdata_i[d]  = '0;
            bus.device_err_i[d]    = 1'b0;
        end
    endtask

    task automatic set_map(input logic catch_all);
        bus.cfg_device_addr_base[0] = 32'h0010_0000; bus.cfg_device_addr_mask[0] = 32'hFFF0_0000;
        bus.cfg_device_addr_base[1] = 32'h0002_0000; bus.cfg_device_addr_mask[1] = 32'hFFFF_FC00;
        bus.cfg_device_addr_base[2] = catch_all ? 32'h0 : 32'h0003_0000;
        bus.cfg_device_addr_mask[2] = catch_all ? 32'h0 : 32'hFFFF_FC00;
    endtask

    // h_exp < 0 means no host should see a response this cycle.
    task automatic chk_rsp(input string tag, input int h_exp, input logic [31:0] rd, input logic er);
        for (int h = 0; h < NH; h++) begin
            chk($sformatf("%s rvalid h%0d", tag, h), 64'(bus.host_rvalid_o[h]), 64'(h == h_exp));
            chk($sformatf("%s rdata h%0d", tag, h), 64'(bus.host_rdata_o[h]), (h == h_exp) ? 64'(rd) : 64'h0);
            chk($sformatf("%s err h%0d", tag, h), 64'(bus.host_err_o[h]), (h == h_exp) ? 64'(er) : 64'h0);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic rand_phase(input int n, input string tag);
        int pend_h, pend_d, win, dev;
        logic [31:0] rd;
        logic er;
        logic [NH-1:0] eg;
        logic [ND-1:0] ed;
        pend_h = -1;
        pend_d = -1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                bus.device_rvalid_i[d] = 1'($urandom_range(0, 1));
                bus.device_rdata_i[d]  = $urandom;
                bus.device_err_i[d]    = 1'($urandom_range(0, 1));
            end
            rd = '0;
            er = 1'b0;
            if (pend_h >= 0) begin
                if (pend_d >= 0) begin
                    bus.device_rvalid_i[pend_d] = 1'b1;
                    rd = bus.device_rdata_i[pend_d];
                    er = bus.device_err_i[pend_d];
                end else begin
                    er = DECERR;
                end
            end
            win = -1;
            for (int h = 0; h < NH; h++) begin
                bus.host_req_i[h]   = ($urandom_range(0, 3) != 0);
                bus.host_addr_i[h]  = pick_addr();
                bus.host_we_i[h]    = 1'($urandom_range(0, 1));
                bus.host_be_i[h]    = 4'($urandom);
                bus.host_wdata_i[h] = $urandom;
                if (win < 0 && bus.host_req_i[h]) win = h;
            end
            #1;
            chk_rsp(tag, pend_h, rd, er);
            eg = '0;
            ed = '0;
            dev = -1;
            if (win >= 0) begin
                eg[win] = 1'b1;
                dev = decode(bus.host_addr_i[win]);
                if (dev >= 0) ed[dev] = 1'b1;
                chk({tag, " addr"}, 64'(bus.device_addr_o[c % ND]), 64'(bus.host_addr_i[win]));
                chk({tag, " wdata"}, 64'(bus.device_wdata_o[c % ND]), 64'(bus.host_wdata_i[win]));
                chk({tag, " we/be"}, 64'({bus.device_we_o[0], bus.device_be_o[0]}),
                    64'({bus.host_we_i[win], bus.host_be_i[win]}));
            end
            chk({tag, " gnt"}, 64'(gnt_v()), 64'(eg));
            chk({tag, " dreq"}, 64'(dreq_v()), 64'(ed));
            pend_h = win;
            pend_d = dev;
        end
    endtask

    vec_t vt [9];

    initial begin
        vt[0] = '{2'b01, 32'h0010_0010, 32'h0, 1'b0, 4'hF, 32'h0,  32'hDEAD_BEEF, 1'b0, 2'b01, 3'b001, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vt[1] = '{2'b01, 32'h0002_0004, 32'h0, 1'b1, 4'h1, 32'h41, 32'h0,         1'b0, 2'b01, 3'b010, 1'b1, 32'h0,         1'b0};
        vt[2] = '{2'b01, 32'h0003_0008, 32'h0, 1'b0, 4'hF, 32'h0,  32'h1234_5678, 1'b1, 2'b01, 3'b100, 1'b1, 32'h1234_5678, 1'b1};
        vt[3] = '{2'b01, 32'h4000_0000, 32'h0, 1'b0, 4'hF, 32'h0,  32'hCAFE_F00D, 1'b0, 2'b01, 3'b000, 1'b1, 32'h0,         DECERR};
        vt[4] = '{2'b10, 32'h0, 32'h0010_03FC, 1'b0, 4'hF, 32'h0,  32'h0BAD_CAFE, 1'b0, 2'b10, 3'b001, 1'b1, 32'h0BAD_CAFE, 1'b0};
        vt[5] = '{2'b11, 32'h0002_03FC, 32'h0010_0000, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 1'b0, 2'b01, 3'b010, 1'b1, 32'h1111_2222, 1'b0};
        vt[6] = '{2'b01, 32'h0002_0400, 32'h0, 1'b1, 4'hC, 32'h99, 32'h7777_7777, 1'b0, 2'b01, 3'b000, 1'b1, 32'h0,         DECERR};
        vt[7] = '{2'b01, 32'h0003_03FC, 32'h0, 1'b0, 4'hF, 32'h0,  32'h55AA_55AA, 1'b0, 2'b01, 3'b100, 1'b1, 32'h55AA_55AA, 1'b0};
        vt[8] = '{2'b00, 32'h0010_0000, 32'h0, 1'b0, 4'hF, 32'h0,  32'h1357_9BDF, 1'b0, 2'b00, 3'b000, 1'b0, 32'h0,         1'b0};

        // Reset state: requests are masked and no response is visible.
        drive_idle();
        set_map(1'b0);
        bus.host_req_i[0]  = 1'b1;
        bus.host_addr_i[0] = 32'h0010_0010;
        #1;
        chk("reset gnt", 64'(gnt_v()), 64'h0);
        chk("reset dreq", 64'(dreq_v()), 64'h0);
        chk_rsp("reset", -1, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();

        for (int i = 0; i < 9; i++) begin
            int h_exp;
            @(negedge clk);
            drive_idle();
            for (int h = 0; h < NH; h++) begin
                bus.host_req_i[h]   = vt[i].req[h];
                bus.host_addr_i[h]  = (h == 0) ? vt[i].addr0 : vt[i].addr1;
                bus.host_we_i[h]    = vt[i].we;
                bus.host_be_i[h]    = vt[i].be;
                bus.host_wdata_i[h] = vt[i].wdata;
            end
            #1;
            chk($sformatf("vec%0d gnt", i), 64'(gnt_v()), 64'(vt[i].exp_gnt));
            chk($sformatf("vec%0d dreq", i), 64'(dreq_v()), 64'(vt[i].exp_dreq));
            if (vt[i].exp_gnt != '0) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("vec%0d addr d%0d", i, d), 64'(bus.device_addr_o[d]),
                        64'(vt[i].exp_gnt[0] ? vt[i].addr0 : vt[i].addr1));
                    chk($sformatf("vec%0d we/be/wdata d%0d", i, d),
                        64'({bus.device_we_o[d], bus.device_be_o[d], bus.device_wdata_o[d]}),
                        64'({vt[i].we, vt[i].be, vt[i].wdata}));
                end
            end
            @(negedge clk);
            drive_idle();
            // Every device answers; only the decoded one carries the real data.
            for (int d = 0; d < ND; d++) begin
                bus.device_rvalid_i[d] = 1'b1;
                bus.device_rdata_i[d]  = vt[i].exp_dreq[d] ? vt[i].rdata : (32'hBAD0_0000 | 32'(d));
                bus.device_err_i[d]    = vt[i].exp_dreq[d] ? vt[i].err : 1'b1;
            end
            #1;
            h_exp = !vt[i].exp_rvalid ? -1 : (vt[i].exp_gnt[0] ? 0 : 1);
            chk_rsp($sformatf("vec%0d rsp", i), h_exp, vt[i].exp_rdata, vt[i].exp_err);
        end

        // Arbitration: host1 waits one cycle, responses go to their owners.
        idle_cycle();
        @(negedge clk);
        drive_idle();
        bus.host_req_i[0] = 1'b1; bus.host_addr_i[0] = 32'h0010_0020;
        bus.host_req_i[1] = 1'b1; bus.host_addr_i[1] = 32'h0010_0040;
        #1;
        chk("arb gnt c0", 64'(gnt_v()), 64'b01);
        chk("arb dreq c0", 64'(dreq_v()), 64'b001);
        chk("arb addr c0", 64'(bus.device_addr_o[0]), 64'h0010_0020);
        @(negedge clk);
        bus.host_req_i[0] = 1'b0;
        bus.device_rvalid_i[0] = 1'b1; bus.device_rdata_i[0] = 32'hAAAA_0000;
        #1;
        chk("arb gnt c1", 64'(gnt_v()), 64'b10);
        chk("arb addr c1", 64'(bus.device_addr_o[0]), 64'h0010_0040);
        chk_rsp("arb rsp c1", 0, 32'hAAAA_0000, 1'b0);
        @(negedge clk);
        drive_idle();
        bus.device_rvalid_i[0] = 1'b1; bus.device_rdata_i[0] = 32'hBBBB_1111;
        #1;
        chk_rsp("arb rsp c2", 1, 32'hBBBB_1111, 1'b0);

        // Reset during the response cycle drops the transaction.
        idle_cycle();
        @(negedge clk);
        drive_idle();
        bus.host_req_i[0] = 1'b1; bus.host_addr_i[0] = 32'h0010_0010;
        #1;
        chk("rst gnt pre", 64'(gnt_v()), 64'b01);
        @(posedge clk);
        #1;
        bus.device_rvalid_i[0] = 1'b1; bus.device_rdata_i[0] = 32'h7777_7777;
        #1;
        chk_rsp("rst rsp pre", 0, 32'h7777_7777, 1'b0);
        rst = 1'b1;
        #1;
        chk_rsp("rst rsp during", -1, 32'h0, 1'b0);
        chk("rst gnt during", 64'(gnt_v()), 64'h0);
        chk("rst dreq during", 64'(dreq_v()), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        bus.device_rvalid_i[0] = 1'b1; bus.device_rdata_i[0] = 32'h7777_7777;
        #1;
        chk_rsp("rst rsp after", -1, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        chk_rsp("rst rsp after2", -1, 32'h0, 1'b0);

        idle_cycle();
        rand_phase(300, "rnd map");
        idle_cycle();
        set_map(1'b1);
        idle_cycle();
        rand_phase(300, "rnd overlap");
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
